// File: rtl/fp_sum_reducer.sv
// Tree-reduces cmd_len FP elements to one sum by recirculating adder results through an operand FIFO.
// Latency depends on adder depth and backpressure; results take priority over elements, and the occupancy count reserves FIFO space for sums in flight.
module fp_sum_reducer #(
    parameter int data_format = 0,  // 0: FP32, 1: FP16, 2: FP64
    parameter int DEPTH       = 8,
    parameter int LEN_W       = 16,
    localparam int fp_len     = (data_format == 1) ? 16 : (data_format == 2) ? 64 : 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [fp_len-1:0] elem,
    input  logic              elem_valid,
    output logic              elem_ready,
    output logic [fp_len-1:0] add_a,
    output logic [fp_len-1:0] add_b,
    output logic              add_a_valid,
    output logic              add_b_valid,
    input  logic              add_a_ready,
    input  logic              add_b_ready,
    input  logic [fp_len-1:0] add_sum,
    input  logic              add_sum_valid,
    output logic              add_sum_ready,
    output logic [fp_len-1:0] result,
    output logic              result_valid,
    input  logic              result_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = ((LEN_W > CW) ? LEN_W : CW) + 1;

    logic [1:0]        state;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  elems_in;
    logic [LEN_W-1:0]  adds_out;
    logic [LEN_W-1:0]  adds_done;
    logic [fp_len-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_nxt1;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     fifo_count;
    logic [OW-1:0]     occ;
    logic              in_accum;
    logic              cmd_fire;
    logic              elem_fire;
    logic              sum_fire;
    logic              issue_fire;
    logic              push;
    logic              finish;
    logic [fp_len-1:0] push_dat;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int step);
        int s;
        s = int'(p) + step;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    always_comb begin
        in_accum      = (state == ACCUM);
        // Sums still inside the adder already own a FIFO slot, so a returning result always fits.
        occ           = OW'(fifo_count) + OW'(adds_out - adds_done);
        cmd_ready     = (state == IDLE) && !reset;
        elem_ready    = in_accum && (elems_in < len) && !add_sum_valid && (occ < OW'(DEPTH));
        add_sum_ready = in_accum;
        add_a_valid   = in_accum && (fifo_count >= CW'(2));
        add_b_valid   = add_a_valid;
        rd_ptr_nxt1   = ptr_add(rd_ptr, 1);
        add_a         = mem[rd_ptr];
        add_b         = mem[rd_ptr_nxt1];
        result_valid  = (state == DONE);
        cmd_fire      = cmd_valid && cmd_ready;
        elem_fire     = elem_valid && elem_ready;
        sum_fire      = add_sum_valid && add_sum_ready;
        issue_fire    = add_a_valid && add_a_ready && add_b_ready;
        push          = elem_fire || sum_fire;
        push_dat      = sum_fire ? add_sum : elem;
        finish        = in_accum && (elems_in == len) && (adds_done == len - LEN_W'(1))
                        && (fifo_count == CW'(1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            elems_in   <= '0;
            adds_out   <= '0;
            adds_done  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
            result     <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        len       <= cmd_len;
                        elems_in  <= '0;
                        adds_out  <= '0;
                        adds_done <= '0;
                        if (cmd_len == '0) begin
                            result <= '0;
                            state  <= DONE;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (elem_fire)  elems_in  <= elems_in + LEN_W'(1);
                    if (issue_fire) adds_out  <= adds_out + LEN_W'(1);
                    if (sum_fire)   adds_done <= adds_done + LEN_W'(1);
                    // Pushes only touch the tail, so held operands at the head stay stable.
                    if (push) begin
                        mem[wr_ptr] <= push_dat;
                        wr_ptr      <= ptr_add(wr_ptr, 1);
                    end
                    if (issue_fire)  rd_ptr <= ptr_add(rd_ptr, 2);
                    else if (finish) rd_ptr <= rd_ptr_nxt1;
                    fifo_count <= fifo_count + CW'(push)
                                  - (issue_fire ? CW'(2) : (finish ? CW'(1) : CW'(0)));
                    if (finish) begin
                        result <= mem[rd_ptr];
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
